stopwatch_counter: RTL and testbench
====================================

# stopwatch_counter

Stopwatch timekeeping core; sits directly downstream of the clock divider and consumes its 1 Hz and 2 Hz outputs. It brings the divided clocks and button levels into the single system clock domain, then runs a BCD MM:SS counter. The counter supports run/pause, clear and a 2 Hz manual-adjust mode. The four BCD digits feed the seven-segment display multiplexer.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser flops per asynchronous input (minimum 2).

Ports:
- `clk_in`, input, 1: system clock (100 MHz). This is the only clock; divided clocks are sampled as data.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `clk_1Hz`, input, 1: divider output, used as the count rate.
- `clk_2Hz`, input, 1: divider output, used as the adjust rate.
- `pause`, input, 1: debounced button level. A rising edge toggles run/pause.
- `clear`, input, 1: debounced button level. A rising edge zeroes the time.
- `adj`, input, 1: level; 1 selects adjust mode.
- `sel`, input, 1: adjust target; 0 = seconds, 1 = minutes.
- `lap`, input, 1: level; display freeze (see Configuration).
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`, output, 4 each: BCD digits.
- `running`, output, 1: high while in RUN.
- `wrap`, output, 1: one-cycle pulse on the 59:59 → 00:00 rollover.

## Operation
- Every asynchronous input goes through `SYNC_STAGES` flops plus one edge register.
- `tick_1`, `tick_2`, `pause_e` and `clear_e` are single-cycle rising-edge strobes.
- `adj`, `sel` and `lap` are used as synchronised levels.
- States: PAUSED (reset state), RUN, ADJUST.
  - PAUSED → RUN on `pause_e`.
  - RUN → PAUSED on `pause_e`.
  - PAUSED or RUN → ADJUST when synced `adj` = 1. `adj` takes priority over `pause_e` in the same cycle.
  - ADJUST → PAUSED when `adj` = 0.
  - `pause_e` is ignored in ADJUST.
- RUN, on `tick_1`:
  - `sec_ones` +1.
  - 9 → 0 with a carry into `sec_tens`; `sec_tens` 5 → 0 with a carry into minutes, using the same rule.
  - 59:59 → 00:00, with `wrap` asserted for that one cycle.
- ADJUST, on `tick_2`:
  - The field chosen by `sel` increments modulo 60 (59 → 00).
  - No carry into the other field. `wrap` stays low.
  - `tick_1` is ignored.
- PAUSED: all ticks are ignored.
- `clear_e`: digits go to 00:00 in any state and the state is unchanged. `clear_e` wins over a same-cycle tick, and `wrap` is not asserted.
- Digits never leave the range tens 0–5, ones 0–9.
- Reset values:
  - All digits 0.
  - `running` = 0, `wrap` = 0, state PAUSED.
  - Synchroniser and edge registers 0, so a level that is already high when reset releases produces one strobe.
- Reset asserted mid-count clears everything immediately, with no clock required.

## Timing
- Input rising edge → strobe: `SYNC_STAGES` + 1 `clk_in` edges. With the default of 2, the strobe is high in the cycle after the third capturing edge.
- Strobe → digit update: updates on the next edge. Outputs are registered, with no combinational path from inputs to outputs.
- `running` updates on the same edge as the state register.
- `wrap` is coincident with the digits first showing 00:00.
- Each strobe is exactly one `clk_in` cycle wide, regardless of input high time.

## Configuration
- Macro: `STOPWATCH_LAP_EN`.
- Defined:
  - A rising edge of synced `lap` in RUN latches the current digits into output holding registers. Outputs show the latched value while `lap` = 1, and counting continues internally.
  - When `lap` falls, outputs return to live digits on the next edge.
  - `clear_e` or entering ADJUST releases the hold immediately.
- Undefined: `lap` is ignored and outputs always show live digits. The port stays, to keep the interface fixed.

## Structure
- `stopwatch_pkg` holds:
  - The state enum (PAUSED, RUN, ADJUST).
  - The 4-bit `bcd_t` typedef.
  - Constants `ONES_MAX` = 9 and `TENS_MAX` = 5.
- Sub-module `sync_edge` (synchroniser chain plus rising-edge detector, parameter `SYNC_STAGES`) outputs the synced level and the strobe. It is instantiated once per asynchronous input.

## Test plan
- Reset then `pause` pulse, 5 `clk_1Hz` rising edges → `running` = 1, digits 00:05; pulse `pause` again, 3 more edges → still 00:05, `running` = 0.
- Preload via adjust to 59:58, run, 2 `clk_1Hz` edges → 59:59, then 00:00 with exactly one `clk_in`-cycle `wrap` pulse.
- `adj` = 1, `sel` = 1 from 58:10, 3 `clk_2Hz` edges → 59:10, 00:10, 01:10; seconds are unchanged and `wrap` is never asserted.
- `clear` rising edge arranged to reach its strobe in the same cycle as `tick_1` in RUN at 12:34 → 00:00 next cycle, `running` stays 1.
- Assert `rst_n` low mid-count at 07:21 without a clock edge → all outputs 0 immediately; after release with `clk_1Hz` held high → no count, state PAUSED.
- With `STOPWATCH_LAP_EN`, `lap` high at 00:10 for 4 `clk_1Hz` edges → outputs hold 00:10; `lap` low → 00:14 next cycle. Without the macro, outputs show 00:14 throughout.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
// Includes the mod-60 BCD increment used by both the run and adjust paths.
package stopwatch_pkg;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      PAUSED = 2'd0,
      RUN    = 2'd1,
      ADJUST = 2'd2
   } state_e;

   localparam bcd_t ONES_MAX = 4'd9;
   localparam bcd_t TENS_MAX = 4'd5;

   typedef struct packed {
      bcd_t min_tens;
      bcd_t min_ones;
      bcd_t sec_tens;
      bcd_t sec_ones;
   } mmss_t;

   typedef struct packed {
      logic carry;
      bcd_t tens;
      bcd_t ones;
   } bcd60_t;

   // Two-digit BCD increment modulo 60; carry flags the 59 -> 00 rollover.
   function automatic bcd60_t bcd60_inc(input bcd_t tens, input bcd_t ones);
      bcd60_t r;
      r.carry = 1'b0;
      r.tens  = tens;
      r.ones  = ones + 4'd1;
      if (ones >= ONES_MAX) begin
         r.ones = '0;
         if (tens >= TENS_MAX) begin
            r.tens  = '0;
            r.carry = 1'b1;
         end else begin
            r.tens = tens + 4'd1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Stopwatch bundle: divided clocks and button levels in, BCD time and status out.
// master drives the inputs (divider/buttons side), slave is the timekeeping core.
interface stopwatch_counter_if;
   import stopwatch_pkg::*;

   logic clk_1Hz;
   logic clk_2Hz;
   logic pause;
   logic clear;
   logic adj;
   logic sel;
   logic lap;
   bcd_t min_tens;
   bcd_t min_ones;
   bcd_t sec_tens;
   bcd_t sec_ones;
   logic running;
   logic wrap;

   modport master (
      output clk_1Hz, clk_2Hz, pause, clear, adj, sel, lap,
      input  min_tens, min_ones, sec_tens, sec_ones, running, wrap
   );

   modport slave (
      input  clk_1Hz, clk_2Hz, pause, clear, adj, sel, lap,
      output min_tens, min_ones, sec_tens, sec_ones, running, wrap
   );

endinterface

// File: rtl/stopwatch_counter_sync_edge.sv
// sync_edge: SYNC_STAGES-flop synchroniser plus registered rising-edge strobe.
// Latency: level after SYNC_STAGES edges, one-cycle strobe after SYNC_STAGES+1; no backpressure.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic din,
   output logic lvl,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   rise_q, rise_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
      prev_d = sync_q[SYNC_STAGES-1];
      rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
      end
   end

   assign lvl  = sync_q[SYNC_STAGES-1];
   assign rise = rise_q;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch MM:SS BCD core with PAUSED/RUN/ADJUST modes; lap display hold under STOPWATCH_LAP_EN.
// Latency: input edge to digits SYNC_STAGES+2 clk_in edges; no backpressure, outputs registered.
module stopwatch_counter
   import stopwatch_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input logic                clk_in,
   input logic                rst_n,
   stopwatch_counter_if.slave bus
);

   localparam logic [1:0] S_PAUSED = 2'(PAUSED);
   localparam logic [1:0] S_RUN    = 2'(RUN);
   localparam logic [1:0] S_ADJUST = 2'(ADJUST);

   localparam int N_IN = 7;

   logic [N_IN-1:0] raw, lvl, rise;

   assign raw = {bus.lap, bus.sel, bus.adj, bus.clear, bus.pause, bus.clk_2Hz, bus.clk_1Hz};

   for (genvar i = 0; i < N_IN; i++) begin : g_sync
      sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk_in (clk_in),
         .rst_n  (rst_n),
         .din    (raw[i]),
         .lvl    (lvl[i]),
         .rise   (rise[i])
      );
   end

   logic tick_1, tick_2, pause_e, clear_e, adj_lvl, sel_lvl;
   assign tick_1  = rise[0];
   assign tick_2  = rise[1];
   assign pause_e = rise[2];
   assign clear_e = rise[3];
   assign adj_lvl = lvl[4];
   assign sel_lvl = lvl[5];

   logic [1:0] state_q, state_d;
   mmss_t      time_q, time_d;
   logic       running_q, running_d;
   logic       wrap_q, wrap_d;
   bcd60_t     sec_inc, min_inc;

   always_comb begin
      state_d = state_q;
      time_d  = time_q;
      wrap_d  = 1'b0;
      sec_inc = bcd60_inc(time_q.sec_tens, time_q.sec_ones);
      min_inc = bcd60_inc(time_q.min_tens, time_q.min_ones);

      // adj wins over a same-cycle pause edge; any unknown encoding falls back to PAUSED.
      if (adj_lvl) begin
         state_d = S_ADJUST;
      end else if (state_q != S_RUN && state_q != S_PAUSED) begin
         state_d = S_PAUSED;
      end else if (pause_e) begin
         state_d = (state_q == S_RUN) ? S_PAUSED : S_RUN;
      end

      if (clear_e) begin
         time_d = '0;
      end else if (state_q == S_RUN && tick_1) begin
         time_d.sec_tens = sec_inc.tens;
         time_d.sec_ones = sec_inc.ones;
         if (sec_inc.carry) begin
            time_d.min_tens = min_inc.tens;
            time_d.min_ones = min_inc.ones;
            wrap_d          = min_inc.carry;
         end
      end else if (state_q == S_ADJUST && tick_2) begin
         if (sel_lvl) begin
            time_d.min_tens = min_inc.tens;
            time_d.min_ones = min_inc.ones;
         end else begin
            time_d.sec_tens = sec_inc.tens;
            time_d.sec_ones = sec_inc.ones;
         end
      end

      running_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_PAUSED;
         time_q    <= '0;
         running_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         time_q    <= time_d;
         running_q <= running_d;
         wrap_q    <= wrap_d;
      end
   end

   mmss_t disp;

`ifdef STOPWATCH_LAP_EN
   logic  hold_q, hold_d;
   mmss_t lap_q, lap_d;

   always_comb begin
      hold_d = hold_q;
      lap_d  = lap_q;
      if (clear_e || state_d == S_ADJUST || !lvl[6]) begin
         hold_d = 1'b0;
      end else if (rise[6] && state_q == S_RUN) begin
         hold_d = 1'b1;
         lap_d  = time_q;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= 1'b0;
         lap_q  <= '0;
      end else begin
         hold_q <= hold_d;
         lap_q  <= lap_d;
      end
   end

   assign disp = hold_q ? lap_q : time_q;

   logic unused_sync;
   assign unused_sync = ^{lvl[3:0], rise[5:4]};
`else
   assign disp = time_q;

   // lap stays on the interface but has no effect in this build.
   logic unused_sync;
   assign unused_sync = ^{lvl[6], lvl[3:0], rise[6:4]};
`endif

   assign bus.min_tens = disp.min_tens;
   assign bus.min_ones = disp.min_ones;
   assign bus.sec_tens = disp.sec_tens;
   assign bus.sec_ones = disp.sec_ones;
   assign bus.running  = running_q;
   assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: seconds-count model checked every cycle, plus literal time checks.
`timescale 1ns/1ps
module tb_stopwatch_counter;
   import stopwatch_pkg::*;

   logic clk_in = 1'b0;
   logic rst_n  = 1'b0;

   stopwatch_counter_if bus();

   stopwatch_counter #(.SYNC_STAGES(2)) dut (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   int n_cmp    = 0;
   int n_fail   = 0;
   int wrap_cnt = 0;

   localparam int MP = 0, MR = 1, MA = 2;
   localparam int I_T1 = 0, I_T2 = 1, I_PAUSE = 2, I_CLEAR = 3, I_ADJ = 4, I_SEL = 5, I_LAP = 6;

   // Model: time kept as total seconds; input views derived from per-edge sample history.
   logic [6:0] hist [4];
   int         m_mode, m_secs, m_held;
   bit         m_hold, m_wrap, m_run;

   always @(posedge clk_in or negedge rst_n) begin : p_model
      logic [6:0] cur, lv, st;
      int nxt, old;
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) hist[k] = '0;
         m_mode = MP; m_secs = 0; m_held = 0;
         m_hold = 0; m_wrap = 0; m_run = 0;
      end else begin
         cur = {bus.lap, bus.sel, bus.adj, bus.clear, bus.pause, bus.clk_2Hz, bus.clk_1Hz};
         lv  = hist[1];
         st  = hist[2] & ~hist[3];
         old = m_secs;
         m_wrap = 0;
         if (lv[I_ADJ]) nxt = MA;
         else if (m_mode == MA) nxt = MP;
         else if (st[I_PAUSE]) nxt = (m_mode == MR) ? MP : MR;
         else nxt = m_mode;

         if (st[I_CLEAR]) m_secs = 0;
         else if (m_mode == MR && st[I_T1]) begin
            if (m_secs == 3599) begin m_secs = 0; m_wrap = 1; end
            else m_secs = m_secs + 1;
         end else if (m_mode == MA && st[I_T2]) begin
            if (lv[I_SEL]) m_secs = ((m_secs / 60 + 1) % 60) * 60 + m_secs % 60;
            else           m_secs = (m_secs / 60) * 60 + (m_secs % 60 + 1) % 60;
         end
`ifdef STOPWATCH_LAP_EN
         if (st[I_CLEAR] || nxt == MA || !lv[I_LAP]) m_hold = 0;
         else if (st[I_LAP] && m_mode == MR) begin m_hold = 1; m_held = old; end
`endif
         m_mode = nxt;
         m_run  = (nxt == MR);
         hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = cur;
      end
   end

   function automatic logic [15:0] to_bcd(input int s);
      int mm, ss;
      mm = s / 60;
      ss = s % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic logic [15:0] dut_time();
      return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
   endfunction

   function automatic logic [15:0] model_time();
      return to_bcd(m_hold ? m_held : m_secs);
   endfunction

   always @(negedge clk_in) begin : p_cmp
      logic [17:0] exp_v, act_v;
      if (rst_n) begin
         exp_v = {model_time(), m_run, m_wrap};
         act_v = {dut_time(), bus.running, bus.wrap};
         n_cmp++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle @%0t: dut time=%h run=%b wrap=%b, model time=%h run=%b wrap=%b",
                     $time, act_v[17:2], act_v[1], act_v[0], exp_v[17:2], exp_v[1], exp_v[0]);
         end
         if (bus.wrap === 1'b1) wrap_cnt++;
      end
   end

   task automatic chk(input string name, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
      end
   endtask

   task automatic chk_time(input string name, input logic [15:0] exp_v);
      chk({name, " dut"}, int'(dut_time()), int'(exp_v));
      chk({name, " model"}, int'(model_time()), int'(exp_v));
   endtask

   task automatic drive(input int idx, input logic v);
      case (idx)
         I_T1:    bus.clk_1Hz = v;
         I_T2:    bus.clk_2Hz = v;
         I_PAUSE: bus.pause   = v;
         I_CLEAR: bus.clear   = v;
         I_ADJ:   bus.adj     = v;
         I_SEL:   bus.sel     = v;
         default: bus.lap     = v;
      endcase
   endtask

   task automatic pulse(input int idx, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk_in); drive(idx, 1'b1);
         repeat (6) @(negedge clk_in);
         drive(idx, 1'b0);
         repeat (5) @(negedge clk_in);
      end
   endtask

   task automatic level(input int idx, input logic v);
      @(negedge clk_in); drive(idx, v);
      repeat (6) @(negedge clk_in);
   endtask

   // Reach mm:ss through adjust mode from wherever the time currently is, ending PAUSED.
   task automatic preload(input int mm, input int ss);
      pulse(I_CLEAR, 1);
      level(I_ADJ, 1'b1);
      level(I_SEL, 1'b0);
      pulse(I_T2, ss);
      level(I_SEL, 1'b1);
      pulse(I_T2, mm);
      level(I_ADJ, 1'b0);
   endtask

   int wc;

   initial begin
      bus.clk_1Hz = 0; bus.clk_2Hz = 0; bus.pause = 0; bus.clear = 0;
      bus.adj = 0; bus.sel = 0; bus.lap = 0;
      repeat (3) @(negedge clk_in);
      rst_n = 1'b1;
      repeat (4) @(negedge clk_in);
      chk_time("reset time", 16'h0000);
      chk("reset running", int'(bus.running), 0);

      // Run/pause
      pulse(I_PAUSE, 1);
      pulse(I_T1, 5);
      chk_time("run 5 ticks", 16'h0005);
      chk("running after pause edge", int'(bus.running), 1);
      pulse(I_PAUSE, 1);
      pulse(I_T1, 3);
      chk_time("paused ticks ignored", 16'h0005);
      chk("running after second pause", int'(bus.running), 0);

      // Rollover with a single wrap pulse
      preload(59, 58);
      chk_time("preload 59:58", 16'h5958);
      chk("paused after adjust", int'(bus.running), 0);
      pulse(I_PAUSE, 1);
      pulse(I_T1, 1);
      chk_time("run to 59:59", 16'h5959);
      wc = wrap_cnt;
      pulse(I_T1, 1);
      chk_time("rollover 00:00", 16'h0000);
      chk("wrap pulse count", wrap_cnt - wc, 1);

      // Minute adjust from 58:10
      level(I_ADJ, 1'b1);
      level(I_SEL, 1'b0);
      pulse(I_T2, 10);
      level(I_SEL, 1'b1);
      pulse(I_T2, 58);
      chk_time("adjust to 58:10", 16'h5810);
      wc = wrap_cnt;
      pulse(I_T2, 1);
      chk_time("adjust 59:10", 16'h5910);
      pulse(I_T2, 1);
      chk_time("adjust 00:10", 16'h0010);
      pulse(I_T2, 1);
      chk_time("adjust 01:10", 16'h0110);
      chk("no wrap in adjust", wrap_cnt - wc, 0);
      level(I_ADJ, 1'b0);

      // Clear coincident with tick_1 in RUN
      preload(12, 34);
      pulse(I_PAUSE, 1);
      chk_time("preload 12:34", 16'h1234);
      wc = wrap_cnt;
      @(negedge clk_in); bus.clear = 1'b1; bus.clk_1Hz = 1'b1;
      repeat (6) @(negedge clk_in);
      bus.clear = 1'b0; bus.clk_1Hz = 1'b0;
      repeat (5) @(negedge clk_in);
      chk_time("clear beats tick", 16'h0000);
      chk("running kept on clear", int'(bus.running), 1);
      chk("no wrap on clear", wrap_cnt - wc, 0);

      // Asynchronous reset mid-count
      preload(7, 21);
      pulse(I_PAUSE, 1);
      chk_time("preload 07:21", 16'h0721);
      @(negedge clk_in); bus.clk_1Hz = 1'b1;
      repeat (2) @(negedge clk_in);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset time", int'(dut_time()), 0);
      chk("async reset running", int'(bus.running), 0);
      chk("async reset wrap", int'(bus.wrap), 0);
      @(negedge clk_in); rst_n = 1'b1;
      repeat (20) @(negedge clk_in);
      chk_time("high 1Hz at release", 16'h0000);
      chk("paused after release", int'(bus.running), 0);
      @(negedge clk_in); bus.clk_1Hz = 1'b0;
      repeat (5) @(negedge clk_in);

      // Lap hold
      pulse(I_PAUSE, 1);
      pulse(I_T1, 10);
      chk_time("run to 00:10", 16'h0010);
      level(I_LAP, 1'b1);
      pulse(I_T1, 4);
`ifdef STOPWATCH_LAP_EN
      chk_time("lap held", 16'h0010);
`else
      chk_time("lap ignored", 16'h0014);
`endif
      level(I_LAP, 1'b0);
      chk_time("after lap release", 16'h0014);
      chk("running through lap", int'(bus.running), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
